// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predictor: funct3 encodings and the
// power-on value of the direction counters.
package branch_predict_unit_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // Weakly not-taken: one below the midpoint, zero for a 1-bit counter.
    function automatic int ctr_reset_value(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-side lookup and execute-side resolution signals of the predictor.
// master = pipeline, slave = branch_predict_unit.
interface branch_predict_unit_if #(
    parameter int XLEN     = 32,
    parameter int CNT_BITS = 16
);
    logic [XLEN-1:0]     i_fetch_pc;
    logic                o_pred_taken;
    logic                i_ex_valid;
    logic                i_ex_branch;
    logic [XLEN-1:0]     i_ex_pc;
    logic [2:0]          i_ex_funct3;
    logic                i_ex_eq;
    logic                i_ex_slt;
    logic                i_ex_pred_taken;
    logic                o_ex_take_branch;
    logic                o_ex_mispredict;
    logic [CNT_BITS-1:0] o_mispredict_count;

    modport master (
        output i_fetch_pc, i_ex_valid, i_ex_branch, i_ex_pc, i_ex_funct3,
               i_ex_eq, i_ex_slt, i_ex_pred_taken,
        input  o_pred_taken, o_ex_take_branch, o_ex_mispredict, o_mispredict_count
    );

    modport slave (
        input  i_fetch_pc, i_ex_valid, i_ex_branch, i_ex_pc, i_ex_funct3,
               i_ex_eq, i_ex_slt, i_ex_pred_taken,
        output o_pred_taken, o_ex_take_branch, o_ex_mispredict, o_mispredict_count
    );
endinterface

// File: rtl/branch_predict_unit_branch_resolve.sv
// Combinational branch resolver: funct3 plus ALU compare flags to direction.
// Reserved funct3 (010, 011) and bubbles resolve as not-a-branch.
module branch_resolve
    import branch_predict_unit_pkg::*;
(
    input  logic       valid,
    input  logic       branch,
    input  logic [2:0] funct3,
    input  logic       eq,
    input  logic       slt,
    output logic       legal,
    output logic       take
);
    logic cond;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            BEQ:         cond = eq;
            BNE:         cond = ~eq;
            BLT, BLTU:   cond = slt;
            BGE, BGEU:   cond = ~slt;
            default:     cond = 1'b0;
        endcase
    end

    assign legal = valid & branch & (funct3 != 3'b010) & (funct3 != 3'b011);
    assign take  = legal & cond;

endmodule

// File: rtl/branch_predict_unit.sv
// PC-indexed table of saturating counters: predicts at fetch, resolves and
// trains at execute, and keeps a saturating misprediction count.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int CNT_BITS   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    branch_predict_unit_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_reset_value(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    logic [CTR_BITS-1:0]   table_q [ENTRIES];
    logic [CNT_BITS-1:0]   count_q;
    logic [INDEX_BITS-1:0] fetch_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [CTR_BITS-1:0]   ex_ctr;
    logic [CTR_BITS-1:0]   ex_ctr_next;
    logic                  legal;
    logic                  take;
    logic                  mispredict;
    logic                  unused_pc_bits;

    assign fetch_idx = bus.i_fetch_pc[INDEX_BITS+1:2];
    assign ex_idx    = bus.i_ex_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{bus.i_fetch_pc[XLEN-1:INDEX_BITS+2], bus.i_fetch_pc[1:0],
                              bus.i_ex_pc[XLEN-1:INDEX_BITS+2], bus.i_ex_pc[1:0]};

    branch_resolve u_resolve (
        .valid  (bus.i_ex_valid),
        .branch (bus.i_ex_branch),
        .funct3 (bus.i_ex_funct3),
        .eq     (bus.i_ex_eq),
        .slt    (bus.i_ex_slt),
        .legal  (legal),
        .take   (take)
    );

    assign mispredict = legal & (take != bus.i_ex_pred_taken);

    // Lookup reads the registered table directly, so a same-cycle update is not visible.
    assign bus.o_pred_taken       = table_q[fetch_idx][CTR_BITS-1];
    assign bus.o_ex_take_branch   = take;
    assign bus.o_ex_mispredict    = mispredict;
    assign bus.o_mispredict_count = count_q;

    assign ex_ctr = table_q[ex_idx];

    always_comb begin
        ex_ctr_next = ex_ctr;
        if (take) begin
            if (ex_ctr != CTR_MAX) ex_ctr_next = ex_ctr + CTR_ONE;
        end else begin
            if (ex_ctr != '0) ex_ctr_next = ex_ctr - CTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_INIT;
            count_q <= '0;
        end else begin
            if (legal) table_q[ex_idx] <= ex_ctr_next;
            if (mispredict && (count_q != '1)) count_q <= count_q + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed plus randomised bench for branch_predict_unit; expectations come
// from an independent integer model through a scoreboard queue.
module tb_branch_predict_unit;

    typedef struct {
        logic       pred;
        logic       take;
        logic       misp;
        logic [3:0] cnt;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   mdl_tbl [64];
    int   mdl_cnt;
    exp_t sb [$];

    always #5 clk = ~clk;

    branch_predict_unit_if #(.XLEN(32), .CNT_BITS(4)) bus ();

    branch_predict_unit #(
        .XLEN(32), .INDEX_BITS(6), .CTR_BITS(2), .CNT_BITS(4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic mdl_reset();
        for (int i = 0; i < 64; i++) mdl_tbl[i] = 1;
        mdl_cnt = 0;
    endtask

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $error("FAIL scoreboard empty");
            return;
        end
        e = sb.pop_front();
        total++;
        assert (bus.o_pred_taken === e.pred) else begin
            bad++; $error("FAIL %s pred got=%b exp=%b", e.tag, bus.o_pred_taken, e.pred);
        end
        total++;
        assert (bus.o_ex_take_branch === e.take) else begin
            bad++; $error("FAIL %s take got=%b exp=%b", e.tag, bus.o_ex_take_branch, e.take);
        end
        total++;
        assert (bus.o_ex_mispredict === e.misp) else begin
            bad++; $error("FAIL %s misp got=%b exp=%b", e.tag, bus.o_ex_mispredict, e.misp);
        end
        total++;
        assert (bus.o_mispredict_count === e.cnt) else begin
            bad++; $error("FAIL %s count got=%0d exp=%0d", e.tag, bus.o_mispredict_count, e.cnt);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++; $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, then clock the model.
    task automatic drive(input string tag, input bit r, input logic [31:0] fpc,
                         input logic [31:0] xpc, input bit v, input bit b,
                         input logic [2:0] f3, input bit eq, input bit slt, input bit pt);
        exp_t e;
        int   fi, xi;
        bit   lg, tk;
        @(negedge clk);
        rst = r;
        bus.i_fetch_pc = fpc; bus.i_ex_pc = xpc; bus.i_ex_valid = v;
        bus.i_ex_branch = b; bus.i_ex_funct3 = f3; bus.i_ex_eq = eq;
        bus.i_ex_slt = slt; bus.i_ex_pred_taken = pt;
        fi = int'(fpc[7:2]);
        xi = int'(xpc[7:2]);
        lg = v && b && (f3 != 3'd2) && (f3 != 3'd3);
        case (f3)
            3'd0: tk = eq;
            3'd1: tk = !eq;
            3'd4, 3'd6: tk = slt;
            3'd5, 3'd7: tk = !slt;
            default: tk = 1'b0;
        endcase
        tk = lg && tk;
        e.pred = (mdl_tbl[fi] >= 2);
        e.take = tk;
        e.misp = lg && (tk != pt);
        e.cnt  = 4'(mdl_cnt);
        e.tag  = tag;
        sb.push_back(e);
        #2;
        check_front();
        @(posedge clk);
        if (r) mdl_reset();
        else begin
            if (lg) begin
                if (tk && mdl_tbl[xi] < 3) mdl_tbl[xi]++;
                else if (!tk && mdl_tbl[xi] > 0) mdl_tbl[xi]--;
            end
            if (e.misp && mdl_cnt < 15) mdl_cnt++;
        end
    endtask

    task automatic idle(input string tag, input logic [31:0] fpc);
        drive(tag, 1'b0, fpc, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] pc_a, pc_b;
        bus.i_fetch_pc = '0; bus.i_ex_pc = '0; bus.i_ex_valid = 1'b0;
        bus.i_ex_branch = 1'b0; bus.i_ex_funct3 = '0; bus.i_ex_eq = 1'b0;
        bus.i_ex_slt = 1'b0; bus.i_ex_pred_taken = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk);

        idle("reset_pred", 32'h100);
        #1 chk("reset_count", 32'(bus.o_mispredict_count), 32'd0);

        // beq taken twice: 01 -> 10 -> 11
        drive("beq1", 0, 32'h100, 32'h100, 1, 1, 3'd0, 1, 0, 0);
        drive("beq2", 0, 32'h100, 32'h100, 1, 1, 3'd0, 1, 0, 0);
        idle("beq_after", 32'h100);
        #1 chk("beq_pred", 32'(bus.o_pred_taken), 32'd1);
        chk("beq_count", 32'(bus.o_mispredict_count), 32'd2);

        // bne not taken to floor, then one taken step
        repeat (4) drive("bne_nt", 0, 32'h200, 32'h200, 1, 1, 3'd1, 1, 0, 0);
        drive("bne_t", 0, 32'h200, 32'h200, 1, 1, 3'd1, 0, 0, 0);
        idle("bne_after", 32'h200);
        #1 chk("bne_pred", 32'(bus.o_pred_taken), 32'd0);

        // Same-cycle fetch/update: old value first, new value next cycle, alias too
        drive("alias_same", 0, 32'h104, 32'h104, 1, 1, 3'd0, 1, 0, 0);
        idle("alias_next", 32'h104);
        idle("alias_204", 32'h204);
        #1 chk("alias_204_pred", 32'(bus.o_pred_taken), 32'd1);

        // Non-branches never resolve or train
        drive("rsvd010", 0, 32'h140, 32'h140, 1, 1, 3'd2, 1, 0, 1);
        drive("rsvd011", 0, 32'h140, 32'h140, 1, 1, 3'd3, 0, 1, 1);
        drive("invalid", 0, 32'h140, 32'h140, 0, 1, 3'd0, 1, 0, 0);
        drive("notbr", 0, 32'h140, 32'h140, 1, 0, 3'd0, 1, 0, 0);
        idle("illegal_after", 32'h140);

        // Compare-based funct3 variants with both slt values
        for (int k = 4; k < 8; k++) begin
            for (int s = 0; s < 2; s++) begin
                pc_a = 32'h180 + 32'(k * 4);
                drive("slt_f3", 0, pc_a, pc_a, 1, 1, 3'(k), 0, s[0], 1);
                drive("slt_f3b", 0, pc_a, pc_a, 1, 1, 3'(k), 1, s[0], 0);
            end
        end

        // Statistics counter saturates at 15
        repeat (20) drive("cnt_sat", 0, 32'h300, 32'h300, 1, 1, 3'd0, 1, 0, 0);
        idle("cnt_hold", 32'h300);
        #1 chk("cnt_sat_val", 32'(bus.o_mispredict_count), 32'd15);

        // Reset beats a concurrent taken update
        drive("rst_upd", 1, 32'h300, 32'h400, 1, 1, 3'd0, 1, 0, 0);
        idle("rst_after", 32'h300);
        #1 chk("rst_count", 32'(bus.o_mispredict_count), 32'd0);
        idle("rst_400", 32'h400);
        drive("post_rst", 0, 32'h400, 32'h400, 1, 1, 3'd0, 1, 0, 0);
        idle("post_rst_pred", 32'h400);
        #1 chk("post_rst_10", 32'(bus.o_pred_taken), 32'd1);

        // Randomised traffic over a small set of indices
        for (int n = 0; n < 60; n++) begin
            pc_a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            pc_b = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            drive("rand", 0, pc_a, pc_b, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
